// File: rtl/timer_device.sv
// Memory-mapped countdown timer responding on the MEM-stage bridge (CTRL/PRESET/COUNT window).
// Optional macro TIMER_PRESCALER_EN adds a PRESCALE register at +0xC and a 16-bit count divider.
module timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bridge_address,
  input  logic [31:0] bridge_write_data,
  input  logic [2:0]  bridge_write_size,
  input  logic [2:0]  bridge_read_size,
  output logic [31:0] bridge_read_data,
  output logic        accepted,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [2:0] SZ_WORD = 3'd4;

  function automatic logic size_active(input logic [2:0] sz);
    return (sz == 3'd1) || (sz == 3'd2) || (sz == 3'd4);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_pending_q, irq_pending_d;
  logic        irq_q, irq_d;

  logic        in_window_s, aligned_s, rd_word_s, wr_word_s;
  logic        rd_mapped_s, wr_mapped_s;
  logic [1:0]  offset_s;
  logic [31:0] reg_data_s;
  logic        ctrl_wr_s, preset_wr_s;
  logic        en_clr_s, irq_set_s, irq_clr_s, step_s;

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] div_q, div_d;
  logic        prescale_wr_s;
`endif

  // Address/size decode and zero-latency read mux
  always_comb begin
    in_window_s = (bridge_address[31:4] == BASE_ADDR[31:4]);
    aligned_s   = (bridge_address[1:0] == 2'b00);
    offset_s    = bridge_address[3:2];
    // a word access in one direction only; any live size on the other side rejects it
    rd_word_s   = (bridge_read_size == SZ_WORD) && !size_active(bridge_write_size);
    wr_word_s   = (bridge_write_size == SZ_WORD) && !size_active(bridge_read_size);
    reg_data_s  = 32'h0000_0000;
    rd_mapped_s = 1'b0;
    wr_mapped_s = 1'b0;
    case (offset_s)
      2'd0: begin
        reg_data_s  = {28'h000_0000, ctrl_q};
        rd_mapped_s = 1'b1;
        wr_mapped_s = 1'b1;
      end
      2'd1: begin
        reg_data_s  = preset_q;
        rd_mapped_s = 1'b1;
        wr_mapped_s = 1'b1;
      end
      2'd2: begin
        reg_data_s  = count_q;
        rd_mapped_s = 1'b1;
        wr_mapped_s = 1'b0;
      end
      2'd3: begin
`ifdef TIMER_PRESCALER_EN
        reg_data_s  = {16'h0000, prescale_q};
        rd_mapped_s = 1'b1;
        wr_mapped_s = 1'b1;
`else
        reg_data_s  = 32'h0000_0000;
        rd_mapped_s = 1'b0;
        wr_mapped_s = 1'b0;
`endif
      end
      default: begin
        reg_data_s  = 32'h0000_0000;
        rd_mapped_s = 1'b0;
        wr_mapped_s = 1'b0;
      end
    endcase
    accepted = in_window_s && aligned_s &&
               ((rd_word_s && rd_mapped_s) || (wr_word_s && wr_mapped_s));
    bridge_read_data = (accepted && rd_word_s) ? reg_data_s : 32'h0000_0000;
    ctrl_wr_s   = accepted && wr_word_s && (offset_s == 2'd0);
    preset_wr_s = accepted && wr_word_s && (offset_s == 2'd1);
  end

`ifdef TIMER_PRESCALER_EN
  assign prescale_wr_s = accepted && wr_word_s && (offset_s == 2'd3);
  assign step_s        = (div_q == prescale_q);
`else
  assign step_s        = 1'b1;
`endif

  // Countdown FSM next-state and register update rules
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    en_clr_s  = 1'b0;
    irq_set_s = 1'b0;
    irq_clr_s = 1'b0;
`ifdef TIMER_PRESCALER_EN
    div_d      = div_q;
    prescale_d = prescale_wr_s ? bridge_write_data[15:0] : prescale_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) state_d = ST_LOAD;
        else           state_d = ST_IDLE;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
`ifdef TIMER_PRESCALER_EN
        div_d   = 16'h0000;
`endif
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (step_s) begin
`ifdef TIMER_PRESCALER_EN
          div_d = 16'h0000;
`endif
          // PRESET of 0 or 1 both terminate here, so COUNT never wraps
          if (count_q <= 32'd1) begin
            count_d   = 32'd0;
            irq_set_s = 1'b1;
            state_d   = ST_INT;
          end else begin
            count_d = count_q - 32'd1;
            state_d = ST_CNT;
          end
        end else begin
`ifdef TIMER_PRESCALER_EN
          div_d = div_q + 16'd1;
`endif
          state_d = ST_CNT;
        end
      end
      ST_INT: begin
        if (ctrl_q[2:1] == 2'b01) begin
          irq_clr_s = 1'b1;
          state_d   = ST_LOAD;
        end else begin
          en_clr_s  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // a bus write to CTRL overrides both the FSM's EN clear and a fresh interrupt set
    ctrl_d        = ctrl_wr_s ? bridge_write_data[3:0] : {ctrl_q[3:1], ctrl_q[0] & ~en_clr_s};
    irq_pending_d = ctrl_wr_s ? 1'b0 : ((irq_pending_q | irq_set_s) & ~irq_clr_s);
    preset_d      = preset_wr_s ? bridge_write_data : preset_q;
    irq_d         = irq_pending_q & ctrl_q[3];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= 4'h0;
      preset_q      <= 32'h0000_0000;
      count_q       <= 32'h0000_0000;
      irq_pending_q <= 1'b0;
      irq_q         <= 1'b0;
`ifdef TIMER_PRESCALER_EN
      prescale_q    <= 16'h0000;
      div_q         <= 16'h0000;
`endif
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      preset_q      <= preset_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
      irq_q         <= irq_d;
`ifdef TIMER_PRESCALER_EN
      prescale_q    <= prescale_d;
      div_q         <= div_d;
`endif
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed sequence plus randomized one-shot/auto-reload runs
// checked against closed-form expectations of COUNT and irq versus cycles since enable.
module tb_timer_device;

  localparam logic [31:0] A_CTRL = 32'h0000_7f00;
  localparam logic [31:0] A_PRE  = 32'h0000_7f04;
  localparam logic [31:0] A_CNT  = 32'h0000_7f08;
  localparam logic [31:0] A_PSC  = 32'h0000_7f0c;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  wsize, rsize;
  logic        acc, irq;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  timer_device dut (
    .clk               (clk),
    .reset             (reset),
    .bridge_address    (addr),
    .bridge_write_data (wdata),
    .bridge_write_size (wsize),
    .bridge_read_size  (rsize),
    .bridge_read_data  (rdata),
    .accepted          (acc),
    .irq               (irq)
  );

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    addr = 32'h0; wdata = 32'h0; wsize = 3'd0; rsize = 3'd0;
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ws, input logic [2:0] rs);
    @(negedge clk);
    addr = a; wdata = d; wsize = ws; rsize = rs;
    #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input string tag);
    req(a, d, 3'd4, 3'd0);
    chk({tag, "_acc"}, {31'b0, acc}, 32'd1);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic lw_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    req(a, 32'h0, 3'd0, 3'd4);
    chk({tag, "_acc"}, {31'b0, acc}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1 idle();
  endtask

  // One-shot: LOAD one edge after enable, COUNT=P one edge later, INT at edge 2+max(P,1)
  task automatic oneshot(input int p, input logic im);
    int kint;
    int ce;
    kint = 2 + imax(p, 1);
    sw(A_PRE, 32'(p), "os_pre");
    sw(A_CTRL, {28'h0, im, 3'b001}, "os_ctrl");
    for (int k = 1; k <= kint + 2; k++) begin
      @(posedge clk);
      ce = imax(p - (k - 2), 0);
      if (k >= 2) lw_chk(A_CNT, 32'(ce), $sformatf("os_cnt_p%0d_k%0d", p, k));
      else        req(A_CNT, 32'h0, 3'd0, 3'd4);
      chk($sformatf("os_irq_p%0d_k%0d", p, k), {31'b0, irq}, {31'b0, im && (k >= kint + 1)});
    end
    lw_chk(A_CTRL, {28'h0, im, 3'b000}, "os_ctrl_en_cleared");
    sw(A_CTRL, 32'h0, "os_clr");
    @(posedge clk);
    #1 chk("os_irq_after_clr", {31'b0, irq}, 32'd0);
    settle(2);
  endtask

  // Auto-reload: period max(P,1)+2, LOAD at phase 0, irq visible at phase 0 of the following period
  task automatic autoreload(input int p, input logic im);
    int t;
    int j;
    int ce;
    t = imax(p, 1) + 2;
    sw(A_PRE, 32'(p), "ar_pre");
    sw(A_CTRL, {28'h0, im, 3'b011}, "ar_ctrl");
    for (int k = 1; k <= 3 * t + 1; k++) begin
      @(posedge clk);
      j  = (k - 1) % t;
      ce = (j >= 1 && j <= t - 2) ? imax(p - (j - 1), 0) : 0;
      if (k >= 2) lw_chk(A_CNT, 32'(ce), $sformatf("ar_cnt_p%0d_k%0d", p, k));
      else        req(A_CNT, 32'h0, 3'd0, 3'd4);
      chk($sformatf("ar_irq_p%0d_k%0d", p, k), {31'b0, irq}, {31'b0, im && (k > 1) && (j == 0)});
    end
    sw(A_CTRL, 32'h0, "ar_clr");
    settle(6);
    chk("ar_irq_idle", {31'b0, irq}, 32'd0);
  endtask

  logic [31:0] il_a [8];
  logic [31:0] il_d [8];
  logic [2:0]  il_w [8];
  logic [2:0]  il_r [8];
  int          il_n;

  initial begin
    idle();
    reset = 1'b0;
    settle(2);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    lw_chk(A_CTRL, 32'h0, "rst_ctrl");
    lw_chk(A_PRE,  32'h0, "rst_pre");
    lw_chk(A_CNT,  32'h0, "rst_cnt");
    chk("rst_irq2", {31'b0, irq}, 32'd0);
    settle(1);

    // Illegal requests: none accepted, no data, no state change
    sw(A_PRE, 32'h0000_0055, "il_setup_pre");
    sw(A_CTRL, 32'h0000_0008, "il_setup_ctrl");
    il_a[0] = A_CTRL;        il_d[0] = 32'hf; il_w[0] = 3'd1; il_r[0] = 3'd0;
    il_a[1] = A_CNT;         il_d[1] = 32'h7; il_w[1] = 3'd4; il_r[1] = 3'd0;
    il_a[2] = 32'h0000_7f10; il_d[2] = 32'h0; il_w[2] = 3'd0; il_r[2] = 3'd4;
    il_a[3] = 32'h0000_7f02; il_d[3] = 32'h0; il_w[3] = 3'd0; il_r[3] = 3'd4;
    il_a[4] = A_CTRL;        il_d[4] = 32'h1; il_w[4] = 3'd4; il_r[4] = 3'd4;
    il_a[5] = A_PRE;         il_d[5] = 32'h9; il_w[5] = 3'd2; il_r[5] = 3'd0;
    il_a[6] = 32'h0000_8f04; il_d[6] = 32'h9; il_w[6] = 3'd4; il_r[6] = 3'd0;
    il_a[7] = A_PSC;         il_d[7] = 32'h3; il_w[7] = 3'd4; il_r[7] = 3'd0;
`ifdef TIMER_PRESCALER_EN
    il_n = 7;
`else
    il_n = 8;
`endif
    for (int i = 0; i < il_n; i++) begin
      req(il_a[i], il_d[i], il_w[i], il_r[i]);
      chk($sformatf("il_acc_%0d", i), {31'b0, acc}, 32'd0);
      chk($sformatf("il_data_%0d", i), rdata, 32'h0);
      @(posedge clk);
      #1 idle();
    end
    lw_chk(A_CTRL, 32'h0000_0008, "il_ctrl_kept");
    lw_chk(A_PRE,  32'h0000_0055, "il_pre_kept");
    lw_chk(A_CNT,  32'h0000_0000, "il_cnt_kept");
    sw(A_CTRL, 32'h0, "il_cleanup");
    settle(2);

    oneshot(5, 1'b1);
    autoreload(3, 1'b1);
    for (int r = 0; r < 3; r++) begin
      oneshot(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      autoreload(int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
    end

    // CTRL write lands in the INT cycle of a one-shot with PRESET=0 (INT entered at edge 3)
    sw(A_PRE, 32'h0, "sim_pre");
    sw(A_CTRL, 32'h9, "sim_ctrl");
    settle(3);
    sw(A_CTRL, 32'h9, "sim_ctrl_in_int");
    lw_chk(A_CTRL, 32'h9, "sim_en_kept");
    @(posedge clk);
    #1 chk("sim_irq_cleared", {31'b0, irq}, 32'd0);
    sw(A_CTRL, 32'h0, "sim_cleanup");
    settle(6);

`ifdef TIMER_PRESCALER_EN
    sw(A_PSC, 32'hffff_0002, "psc_wr");
    lw_chk(A_PSC, 32'h0000_0002, "psc_rd");
    sw(A_PRE, 32'd2, "psc_pre");
    sw(A_CTRL, 32'h1, "psc_ctrl");
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      if (k >= 2) lw_chk(A_CNT, 32'(imax(2 - (k - 2) / 3, 0)), $sformatf("psc_cnt_k%0d", k));
      else        req(A_CNT, 32'h0, 3'd0, 3'd4);
    end
    sw(A_CTRL, 32'h0, "psc_cleanup");
    settle(4);
`endif

    // Reset while counting, with a bus write in flight
    sw(A_PRE, 32'd200, "rm_pre");
    sw(A_CTRL, 32'hb, "rm_ctrl");
    settle(102);
    lw_chk(A_CNT, 32'd100, "rm_cnt100");
    @(negedge clk);
    reset = 1'b0;
    addr = A_PRE; wdata = 32'h1111_1111; wsize = 3'd4; rsize = 3'd0;
    @(posedge clk);
    #1 idle();
    reset = 1'b1;
    #1;
    chk("rm_rdata", rdata, 32'h0);
    chk("rm_acc", {31'b0, acc}, 32'd0);
    chk("rm_irq", {31'b0, irq}, 32'd0);
    lw_chk(A_CTRL, 32'h0, "rm_ctrl0");
    lw_chk(A_PRE,  32'h0, "rm_pre0");
    lw_chk(A_CNT,  32'h0, "rm_cnt0");
    settle(3);
    lw_chk(A_CNT, 32'h0, "rm_cnt_idle");
    chk("rm_irq_idle", {31'b0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
